fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer. Owns the fetch PC and the instruction-memory request handshake.

---
 rtl/fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: fetch PC, imem handshake, redirects, stalls, IF/ID register
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_plus_4_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;

    logic        new_valid;
    logic [31:0] new_pc;
    logic [31:0] new_inst;
    logic [31:0] target;

    // Word-align the target by masking so every input bit is consumed.
    assign target = redirect_pc_i & 32'hFFFF_FFFC;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        new_valid  = 1'b0;
        new_pc     = pc_q;
        new_inst   = imem_rdata_i;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack_i) begin
                    if (redirect_valid_i) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_q + 32'd4;
                        if (stall_i) begin
                            buf_pc_d   = pc_q;
                            buf_inst_d = imem_rdata_i;
                            state_d    = HOLD;
                        end else begin
                            new_valid = 1'b1;
                            new_pc    = pc_q;
                            new_inst  = imem_rdata_i;
                        end
                    end
                end else if (redirect_valid_i) begin
                    // Request already on the bus must complete before the new target is issued.
                    pend_d  = target;
                    state_d = KILL;
                end
            end
            HOLD: begin
                if (redirect_valid_i) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    new_valid = 1'b1;
                    new_pc    = buf_pc_q;
                    new_inst  = buf_inst_q;
                    state_d   = FETCH;
                end
            end
            KILL: begin
                if (imem_ack_i) begin
                    pc_d    = redirect_valid_i ? target : pend_q;
                    state_d = FETCH;
                end else if (redirect_valid_i) begin
                    pend_d = target;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if (redirect_valid_i) begin
            if_valid_d = 1'b0;
        end else if (!stall_i) begin
            if (new_valid) begin
                if_valid_d = 1'b1;
                if_pc_d    = new_pc;
                if_inst_d  = new_inst;
            end else begin
                if_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pend_q     <= 32'd0;
            buf_pc_q   <= 32'd0;
            buf_inst_q <= 32'd0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'd0;
            if_inst_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    assign imem_req_o     = (state_q == FETCH) || (state_q == KILL);
    assign imem_addr_o    = pc_q;
    assign if_valid_o     = if_valid_q;
    assign if_pc_o        = if_pc_q;
    assign if_inst_o      = if_inst_q;
    assign if_pc_plus_4_o = if_pc_q + 32'd4;
    assign flush_o        = redirect_valid_i & ~reset_i;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed scoreboard testbench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_plus_4_o;
    logic        flush_o;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .stall_i          (stall_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ack_i       (imem_ack_i),
        .imem_rdata_i     (imem_rdata_i),
        .if_valid_o       (if_valid_o),
        .if_pc_o          (if_pc_o),
        .if_inst_o        (if_inst_o),
        .if_pc_plus_4_o   (if_pc_plus_4_o),
        .flush_o          (flush_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check this cycle's request/flush, clock, check IF/ID.
    task automatic step(input logic rst, input logic ack, input logic stall, input logic redir,
                        input logic [31:0] rpc, input logic ereq, input logic [31:0] eaddr,
                        input logic push, input logic pop);
        reset_i          = rst;
        imem_ack_i       = ack;
        stall_i          = stall;
        redirect_valid_i = redir;
        redirect_pc_i    = rpc;
        imem_rdata_i     = ack ? inst_of(eaddr) : 32'hDEAD_BEEF;
        #1;
        chk("imem_req", {31'd0, imem_req_o}, {31'd0, ereq});
        if (ereq) chk("imem_addr", imem_addr_o, eaddr);
        chk("flush", {31'd0, flush_o}, {31'd0, redir & ~rst});
        if (push) sb_q.push_back(eaddr);
        @(posedge clk_i);
        #1;
        if (rst) begin
            exp_valid = 1'b0;
            exp_pc    = 32'd0;
            exp_inst  = 32'd0;
        end else if (redir) begin
            exp_valid = 1'b0;
        end else if (!stall) begin
            if (pop && sb_q.size() > 0) begin
                exp_valid = 1'b1;
                exp_pc    = sb_q.pop_front();
                exp_inst  = inst_of(exp_pc);
            end else begin
                exp_valid = 1'b0;
            end
        end
        chk("if_valid", {31'd0, if_valid_o}, {31'd0, exp_valid});
        chk("if_pc", if_pc_o, exp_pc);
        chk("if_inst", if_inst_o, exp_inst);
        if (exp_valid) chk("if_pc_plus_4", if_pc_plus_4_o, exp_pc + 32'd4);
    endtask

    initial begin
        reset_i          = 1'b1;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'd0;
        stall_i          = 1'b0;
        imem_ack_i       = 1'b0;
        imem_rdata_i     = 32'd0;
        exp_valid        = 1'b0;
        exp_pc           = 32'd0;
        exp_inst         = 32'd0;
        @(posedge clk_i);
        #1;
        // reset: three cycles, outputs zero, flush gated off
        step(1, 0, 0, 1, 32'h40, 0, 32'h0, 0, 0);
        step(1, 1, 0, 0, 32'h0,  0, 32'h0, 0, 0);
        step(1, 0, 1, 0, 32'h0,  0, 32'h0, 0, 0);
        // IDLE: stray ack and redirect ignored
        step(0, 1, 0, 1, 32'h500, 0, 32'h0, 0, 0);
        // zero-wait streaming
        step(0, 1, 0, 0, 32'h0, 1, 32'h0, 1, 1);
        step(0, 1, 0, 0, 32'h0, 1, 32'h4, 1, 1);
        // ack under stall -> HOLD, then release
        step(0, 1, 1, 0, 32'h0, 1, 32'h8, 1, 0);
        step(0, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        step(0, 1, 0, 0, 32'h0, 1, 32'hC, 1, 1);
        // delayed ack with redirect -> KILL
        step(0, 0, 0, 0, 32'h0,   1, 32'h10, 0, 0);
        step(0, 0, 0, 1, 32'h100, 1, 32'h10, 0, 0);
        step(0, 0, 0, 0, 32'h0,   1, 32'h10, 0, 0);
        step(0, 1, 0, 0, 32'h0,   1, 32'h10, 0, 0);
        step(0, 1, 0, 0, 32'h0,   1, 32'h100, 1, 1);
        // KILL: newest redirect wins, redirect beats stall
        step(0, 0, 0, 1, 32'h300, 1, 32'h104, 0, 0);
        step(0, 0, 1, 1, 32'h400, 1, 32'h104, 0, 0);
        step(0, 1, 0, 0, 32'h0,   1, 32'h104, 0, 0);
        step(0, 1, 0, 0, 32'h0,   1, 32'h400, 1, 1);
        // redirect with ack, unaligned target
        step(0, 1, 0, 1, 32'h203, 1, 32'h404, 0, 0);
        step(0, 1, 0, 0, 32'h0,   1, 32'h200, 1, 1);
        // redirect during HOLD with stall
        step(0, 1, 1, 0, 32'h0,   1, 32'h204, 0, 0);
        step(0, 0, 1, 1, 32'h600, 0, 32'h0,   0, 0);
        step(0, 1, 0, 0, 32'h0,   1, 32'h600, 1, 1);
        // KILL ack with simultaneous redirect, then wrap past 2^32
        step(0, 0, 0, 1, 32'h900,       1, 32'h604,       0, 0);
        step(0, 1, 0, 1, 32'hFFFF_FFFE, 1, 32'h604,       0, 0);
        step(0, 1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 1);
        step(0, 1, 0, 0, 32'h0,         1, 32'h0,         1, 1);
        // reset while in KILL
        step(0, 0, 0, 1, 32'h700, 1, 32'h4, 0, 0);
        step(1, 0, 0, 1, 32'h700, 1, 32'h4, 0, 0);
        step(0, 0, 0, 0, 32'h0,   0, 32'h0, 0, 0);
        step(0, 1, 0, 0, 32'h0,   1, 32'h0, 1, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
